// File: rtl/image_reader_pkg.sv
// Shared types and constants for the host-to-FPGA image line reader.
// A CCI-P line carries 16 pixel slots of 32 bits; only the low 24 bits are kept.
package image_reader_pkg;

    localparam int PIX_PER_LINE  = 16;
    localparam int PIX_BITS      = 24;
    localparam int PIX_SLOT_BITS = 32;
    localparam int LINE_BITS     = 512;
    localparam int TAG_BITS      = 16;
    localparam int RESP_BITS     = TAG_BITS + LINE_BITS;

    typedef logic [18:0]           t_pix_addr;
    typedef logic [15:0]           t_line_idx;
    typedef logic [41:0]           t_cl_addr;
    typedef logic [LINE_BITS-1:0]  t_line;
    typedef logic [PIX_BITS-1:0]   t_pixel;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } t_reader_state;

    typedef struct packed {
        t_line_idx mdata;
        t_line     data;
    } t_resp;

    function automatic t_pixel pix_slot(input t_line line, input logic [3:0] k);
        return line[{k, 5'd0} +: PIX_BITS];
    endfunction

endpackage

// File: rtl/image_resp_fifo.sv
// Response FIFO between the CCI-P read port and the pixel unpacker.
// rd_data is a register that always holds the current head entry.
module image_resp_fifo #(
    parameter int WIDTH = 528,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] t_ptr;
    typedef logic [AW:0]   t_cnt;

    logic [WIDTH-1:0] mem [DEPTH];
    t_ptr             wr_ptr;
    t_ptr             rd_ptr;
    t_cnt             count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == t_cnt'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Head register follows the entry that will be at rd_ptr after this edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + t_ptr'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + t_ptr'(1);
            end
            count <= count + t_cnt'(do_push) - t_cnt'(do_pop);
            if (do_pop && count > t_cnt'(1)) begin
                rd_data <= mem[rd_ptr + t_ptr'(1)];
            end else if (do_push && (empty || (do_pop && count == t_cnt'(1)))) begin
                rd_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/image_line_reader.sv
// Loads one image frame from host memory over CCI-P channel 0 and
// unpacks each returned line into 16 writes to the pixel input memory.
module image_line_reader
    import image_reader_pkg::*;
#(
    parameter int NUM_PIXELS      = 307200,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  t_cl_addr         base_addr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             c0tx_valid,
    output t_cl_addr         c0tx_addr,
    output t_line_idx        c0tx_mdata,
    input  logic             c0tx_alm_full,
    input  logic             c0rx_valid,
    input  t_line_idx        c0rx_mdata,
    input  t_line            c0rx_data,
    output logic             pix_we,
    output t_pix_addr        pix_addr,
    output t_pixel           pix_data
);

    localparam int        NUM_LINES = NUM_PIXELS / PIX_PER_LINE;
    localparam t_line_idx N_LINES   = t_line_idx'(NUM_LINES);
    localparam t_line_idx MAX_OUT   = t_line_idx'(MAX_OUTSTANDING);

    t_reader_state state;
    t_reader_state state_next;
    logic          start_ok;

    t_cl_addr      base_q;
    t_line_idx     req_idx;
    t_line_idx     in_flight;
    t_line_idx     lines_done;
    logic          issue;

    logic          rx_valid_q;
    t_line_idx     rx_mdata_q;
    t_line         rx_data_q;
    logic          rx_ok;
    logic          rx_bad;
    t_resp         rx_entry;

    t_resp         fifo_head;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;

    logic          unp_active;
    logic [3:0]    unp_k;
    logic [14:0]   unp_tag;
    t_line         unp_line;
    logic          unp_last;

    logic          unused_bits;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    start_ok   = 1'b1;
                end
            end
            FETCH: begin
                if (req_idx == N_LINES) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (lines_done == N_LINES) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Credits count lines until they leave the FIFO, so it cannot overflow
    assign issue = (state == FETCH) && (req_idx < N_LINES)
                && !c0tx_alm_full && (in_flight < MAX_OUT);

    assign rx_bad   = rx_valid_q && (rx_mdata_q >= N_LINES);
    assign rx_ok    = rx_valid_q && (rx_mdata_q < N_LINES);
    assign rx_entry = '{mdata: rx_mdata_q, data: rx_data_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            req_idx    <= '0;
            in_flight  <= '0;
            lines_done <= '0;
            err        <= 1'b0;
            c0tx_valid <= 1'b0;
            c0tx_addr  <= '0;
            c0tx_mdata <= '0;
            rx_valid_q <= 1'b0;
            rx_mdata_q <= '0;
            rx_data_q  <= '0;
        end else begin
            state      <= state_next;
            rx_valid_q <= c0rx_valid && (state != IDLE);
            rx_mdata_q <= c0rx_mdata;
            rx_data_q  <= c0rx_data;
            c0tx_valid <= issue;
            if (issue) begin
                c0tx_addr  <= base_q + t_cl_addr'(req_idx);
                c0tx_mdata <= req_idx;
                req_idx    <= req_idx + t_line_idx'(1);
            end
            in_flight <= in_flight + t_line_idx'(issue) - t_line_idx'(pop);
            if (unp_last) begin
                lines_done <= lines_done + t_line_idx'(1);
            end
            if (rx_bad) begin
                err <= 1'b1;
            end
            if (start_ok) begin
                base_q     <= base_addr;
                req_idx    <= '0;
                in_flight  <= '0;
                lines_done <= '0;
                err        <= 1'b0;
            end
        end
    end

    image_resp_fifo #(
        .WIDTH (RESP_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (rx_ok),
        .wr_data (rx_entry),
        .pop     (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Tags are below NUM_LINES, so bit 15 never reaches the pixel address
    assign unused_bits = ^{fifo_full, fifo_head.mdata[15]};

    assign pop      = !unp_active && !fifo_empty;
    assign unp_last = unp_active && (unp_k == 4'hF);

    // Pixel 0 goes out on the pop edge so consecutive lines have no bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            unp_active <= 1'b0;
            unp_k      <= '0;
            unp_tag    <= '0;
            unp_line   <= '0;
            pix_we     <= 1'b0;
            pix_addr   <= '0;
            pix_data   <= '0;
        end else begin
            pix_we <= unp_active || pop;
            if (unp_active) begin
                pix_addr <= {unp_tag, unp_k};
                pix_data <= pix_slot(unp_line, unp_k);
                unp_k    <= unp_k + 4'd1;
                if (unp_k == 4'hF) begin
                    unp_active <= 1'b0;
                end
            end else if (pop) begin
                pix_addr   <= {fifo_head.mdata[14:0], 4'd0};
                pix_data   <= pix_slot(fifo_head.data, 4'd0);
                unp_line   <= fifo_head.data;
                unp_tag    <= fifo_head.mdata[14:0];
                unp_k      <= 4'd1;
                unp_active <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_image_line_reader.sv
// Directed bench for image_line_reader: a 64-pixel frame on two instances
// (8 and 2 outstanding lines), checked against hand-computed values.
module tb_image_line_reader;

    localparam int NPIX = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [41:0]  base_addr;
    logic         c0tx_alm_full;
    logic         c0rx_valid;
    logic [15:0]  c0rx_mdata;
    logic [511:0] c0rx_data;
    logic         busy, done, err, c0tx_valid, pix_we;
    logic [41:0]  c0tx_addr;
    logic [15:0]  c0tx_mdata;
    logic [18:0]  pix_addr;
    logic [23:0]  pix_data;

    logic         start2;
    logic         c0rx_valid2;
    logic [15:0]  c0rx_mdata2;
    logic [511:0] c0rx_data2;
    logic         busy2, done2, err2, c0tx_valid2, pix_we2;
    logic [41:0]  c0tx_addr2;
    logic [15:0]  c0tx_mdata2;
    logic [18:0]  pix_addr2;
    logic [23:0]  pix_data2;

    typedef struct {
        logic [41:0] addr;
        logic [15:0] tag;
        int          cyc;
    } req_t;

    typedef struct {
        logic [18:0] addr;
        logic [23:0] data;
        int          cyc;
    } pix_t;

    req_t req_q[$];
    pix_t pix_q[$];
    int   req2_cyc[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   rb, pb, db;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    image_line_reader #(
        .NUM_PIXELS      (NPIX),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .c0tx_valid    (c0tx_valid),
        .c0tx_addr     (c0tx_addr),
        .c0tx_mdata    (c0tx_mdata),
        .c0tx_alm_full (c0tx_alm_full),
        .c0rx_valid    (c0rx_valid),
        .c0rx_mdata    (c0rx_mdata),
        .c0rx_data     (c0rx_data),
        .pix_we        (pix_we),
        .pix_addr      (pix_addr),
        .pix_data      (pix_data)
    );

    image_line_reader #(
        .NUM_PIXELS      (NPIX),
        .MAX_OUTSTANDING (2)
    ) dut2 (
        .clk           (clk),
        .reset         (reset),
        .start         (start2),
        .base_addr     (42'h100),
        .busy          (busy2),
        .done          (done2),
        .err           (err2),
        .c0tx_valid    (c0tx_valid2),
        .c0tx_addr     (c0tx_addr2),
        .c0tx_mdata    (c0tx_mdata2),
        .c0tx_alm_full (1'b0),
        .c0rx_valid    (c0rx_valid2),
        .c0rx_mdata    (c0rx_mdata2),
        .c0rx_data     (c0rx_data2),
        .pix_we        (pix_we2),
        .pix_addr      (pix_addr2),
        .pix_data      (pix_data2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        req_t r;
        pix_t p;
        if (c0tx_valid) begin
            r.addr = c0tx_addr;
            r.tag  = c0tx_mdata;
            r.cyc  = cyc;
            req_q.push_back(r);
        end
        if (pix_we) begin
            p.addr = pix_addr;
            p.data = pix_data;
            p.cyc  = cyc;
            pix_q.push_back(p);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (c0tx_valid2) req2_cyc.push_back(cyc);
    end

    function automatic logic [511:0] make_line(input int l);
        logic [511:0] v;
        for (int k = 0; k < 16; k++)
            v[32*k +: 32] = {8'hA5, 24'(16*l + k)};
        return v;
    endfunction

    function automatic int pix_errs(input int o0, o1, o2, o3);
        int ord [4];
        int e;
        int a;
        ord = '{o0, o1, o2, o3};
        e = 0;
        if (pix_q.size() != pb + NPIX) e++;
        for (int i = 0; i < NPIX && pb + i < pix_q.size(); i++) begin
            a = ord[i/16]*16 + i%16;
            if (pix_q[pb+i].addr !== 19'(a) || pix_q[pb+i].data !== 24'(a))
                e++;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        rb = req_q.size();
        pb = pix_q.size();
        db = done_cnt;
    endtask

    task automatic pulse_start(input logic [41:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_resp(input logic [15:0] t, input logic [511:0] d);
        c0rx_valid = 1'b1;
        c0rx_mdata = t;
        c0rx_data  = d;
        tick();
        c0rx_valid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, output bit ok);
        int i = 0;
        while (req_q.size() < rb + n && i < 100) begin
            tick();
            i++;
        end
        ok = (req_q.size() >= rb + n);
    endtask

    task automatic wait_done(output bit ok);
        int i = 0;
        while (done_cnt == db && i < 300) begin
            tick();
            i++;
        end
        ok = (done_cnt > db);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        c0tx_alm_full = 1'b0;
        c0rx_valid = 1'b0;
        c0rx_valid2 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, done, err, c0tx_valid, pix_we, c0tx_addr, c0tx_mdata,
             pix_addr, pix_data} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b err=%b tx=%b we=%b want all 0",
                     busy, done, err, c0tx_valid, pix_we);
        else passed++;
        total++;
        if ({busy2, c0tx_valid2, pix_we2} !== 3'b000)
            $display("FAIL reset_dut2: got %b want 000", {busy2, c0tx_valid2, pix_we2});
        else passed++;
    endtask

    task automatic test_in_order();
        bit ok;
        int s, r, e, last;
        mark();
        s = cyc;
        pulse_start(42'h1000);
        wait_reqs(4, ok);
        total++;
        if (!ok) $display("FAIL inorder_req_count: got %0d want 4", req_q.size() - rb);
        else passed++;
        for (int i = 0; i < 4 && rb + i < req_q.size(); i++) begin
            total++;
            if ({req_q[rb+i].addr, req_q[rb+i].tag} !== {42'h1000 + 42'(i), 16'(i)})
                $display("FAIL inorder_req[%0d]: got %h/%h want %h/%h", i,
                         req_q[rb+i].addr, req_q[rb+i].tag, 42'h1000 + 42'(i), i);
            else passed++;
        end
        if (req_q.size() > rb) begin
            total++;
            if (req_q[rb].cyc != s + 2)
                $display("FAIL start_latency: got %0d want %0d", req_q[rb].cyc - s, 2);
            else passed++;
        end
        repeat (3) tick();
        total++;
        if (req_q.size() - rb != 4)
            $display("FAIL inorder_no_extra_req: got %0d want 4", req_q.size() - rb);
        else passed++;
        r = cyc;
        for (int l = 0; l < 4; l++) send_resp(16'(l), make_line(l));
        wait_done(ok);
        total++;
        if (!ok) $display("FAIL inorder_done_timeout: got no done want done");
        else passed++;
        e = pix_errs(0, 1, 2, 3);
        total++;
        if (e != 0) $display("FAIL inorder_pixels: got %0d bad want 0", e);
        else passed++;
        if (pix_q.size() >= pb + NPIX) begin
            last = pix_q[pb+NPIX-1].cyc;
            total++;
            if (pix_q[pb].cyc != r + 3)
                $display("FAIL resp_latency: got %0d want 3", pix_q[pb].cyc - r);
            else passed++;
            total++;
            if (last - pix_q[pb].cyc != NPIX - 1)
                $display("FAIL no_bubble: got span %0d want %0d", last - pix_q[pb].cyc, NPIX - 1);
            else passed++;
            total++;
            if (done_cyc != last + 1)
                $display("FAIL done_timing: got %0d want %0d", done_cyc, last + 1);
            else passed++;
        end
        total++;
        if (done_cnt - db != 1 || busy !== 1'b0)
            $display("FAIL inorder_done_busy: got done=%0d busy=%b want 1/0",
                     done_cnt - db, busy);
        else passed++;
    endtask

    task automatic test_out_of_order();
        bit ok;
        int e;
        mark();
        pulse_start(42'h2000);
        wait_reqs(4, ok);
        total++;
        if (!ok || req_q[rb+3].addr !== 42'h2003)
            $display("FAIL ooo_reqs: got %0d reqs want 4 ending 0x2003", req_q.size() - rb);
        else passed++;
        send_resp(16'd3, make_line(3));
        send_resp(16'd1, make_line(1));
        send_resp(16'd0, make_line(0));
        send_resp(16'd2, make_line(2));
        wait_done(ok);
        total++;
        if (!ok) $display("FAIL ooo_done_timeout: got no done want done");
        else passed++;
        e = pix_errs(3, 1, 0, 2);
        total++;
        if (e != 0) $display("FAIL ooo_pixels: got %0d bad want 0", e);
        else passed++;
        if (pix_q.size() > pb) begin
            total++;
            if (done_cyc <= pix_q[pix_q.size()-1].cyc || done_cnt - db != 1)
                $display("FAIL ooo_done_after_last: got done@%0d last@%0d want later",
                         done_cyc, pix_q[pix_q.size()-1].cyc);
            else passed++;
        end
    endtask

    task automatic test_alm_full();
        bit ok;
        int n, e;
        mark();
        n = cyc;
        pulse_start(42'h3000);
        tick();
        c0tx_alm_full = 1'b1;
        repeat (10) tick();
        c0tx_alm_full = 1'b0;
        wait_reqs(4, ok);
        total++;
        if (!ok) $display("FAIL alm_req_count: got %0d want 4", req_q.size() - rb);
        else passed++;
        if (req_q.size() >= rb + 2) begin
            total++;
            if (req_q[rb].cyc != n + 2)
                $display("FAIL alm_first_req: got %0d want %0d", req_q[rb].cyc - n, 2);
            else passed++;
            total++;
            if (req_q[rb+1].cyc != n + 13 || req_q[rb+1].tag !== 16'd1)
                $display("FAIL alm_resume: got cyc %0d tag %0d want 13/1",
                         req_q[rb+1].cyc - n, req_q[rb+1].tag);
            else passed++;
        end
        for (int l = 0; l < 4; l++) send_resp(16'(l), make_line(l));
        wait_done(ok);
        e = pix_errs(0, 1, 2, 3);
        total++;
        if (!ok || e != 0) $display("FAIL alm_frame: got done=%b bad=%0d want 1/0", ok, e);
        else passed++;
    endtask

    task automatic test_err_and_busy_start();
        bit ok;
        int e;
        mark();
        pulse_start(42'h4000);
        tick();
        tick();
        c0tx_alm_full = 1'b1;
        pulse_start(42'h7777);
        c0tx_alm_full = 1'b0;
        wait_reqs(4, ok);
        repeat (3) tick();
        total++;
        if (req_q.size() - rb != 4)
            $display("FAIL busy_start_req_count: got %0d want 4", req_q.size() - rb);
        else passed++;
        for (int i = 0; i < 4 && rb + i < req_q.size(); i++) begin
            total++;
            if ({req_q[rb+i].addr, req_q[rb+i].tag} !== {42'h4000 + 42'(i), 16'(i)})
                $display("FAIL busy_start_req[%0d]: got %h/%h want %h/%h", i,
                         req_q[rb+i].addr, req_q[rb+i].tag, 42'h4000 + 42'(i), i);
            else passed++;
        end
        send_resp(16'h00FF, make_line(9));
        repeat (4) tick();
        total++;
        if (err !== 1'b1 || pix_q.size() != pb)
            $display("FAIL bad_tag: got err=%b writes=%0d want 1/0", err, pix_q.size() - pb);
        else passed++;
        for (int l = 0; l < 4; l++) send_resp(16'(l), make_line(l));
        wait_done(ok);
        e = pix_errs(0, 1, 2, 3);
        total++;
        if (!ok || e != 0 || err !== 1'b1)
            $display("FAIL err_sticky_frame: got done=%b bad=%0d err=%b want 1/0/1", ok, e, err);
        else passed++;
        pulse_start(42'h5000);
        total++;
        if (err !== 1'b0 || busy !== 1'b1)
            $display("FAIL err_clear_on_start: got err=%b busy=%b want 0/1", err, busy);
        else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        int e;
        do_reset();
        mark();
        c0tx_alm_full = 1'b1;
        pulse_start(42'h6000);
        c0tx_alm_full = 1'b0;
        repeat (3) tick();
        c0tx_alm_full = 1'b1;
        tick();
        total++;
        if (req_q.size() - rb != 3 || busy !== 1'b1)
            $display("FAIL midfetch_setup: got %0d reqs busy=%b want 3/1",
                     req_q.size() - rb, busy);
        else passed++;
        reset = 1'b1;
        tick();
        total++;
        if ({busy, done, err, c0tx_valid, pix_we, c0tx_addr, c0tx_mdata,
             pix_addr, pix_data} !== '0)
            $display("FAIL midfetch_reset_outputs: got addr=%h mdata=%h busy=%b want 0",
                     c0tx_addr, c0tx_mdata, busy);
        else passed++;
        reset = 1'b0;
        c0tx_alm_full = 1'b0;
        for (int l = 0; l < 3; l++) send_resp(16'(l), make_line(l));
        repeat (6) tick();
        total++;
        if (pix_q.size() != pb || busy !== 1'b0)
            $display("FAIL late_resp_dropped: got writes=%0d busy=%b want 0/0",
                     pix_q.size() - pb, busy);
        else passed++;
        mark();
        pulse_start(42'h8000);
        wait_reqs(4, ok);
        total++;
        if (!ok || req_q[rb].addr !== 42'h8000 || req_q[rb+3].tag !== 16'd3)
            $display("FAIL restart_reqs: got %0d reqs want 4 from 0x8000", req_q.size() - rb);
        else passed++;
        for (int l = 0; l < 4; l++) send_resp(16'(l), make_line(l));
        wait_done(ok);
        e = pix_errs(0, 1, 2, 3);
        total++;
        if (!ok || e != 0 || done_cnt - db != 1)
            $display("FAIL restart_frame: got done=%0d bad=%0d want 1/0", done_cnt - db, e);
        else passed++;
    endtask

    task automatic test_credits();
        int base, r;
        base = req2_cyc.size();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (20) tick();
        total++;
        if (req2_cyc.size() - base != 2)
            $display("FAIL credit_stall: got %0d reqs want 2", req2_cyc.size() - base);
        else passed++;
        r = cyc;
        c0rx_valid2 = 1'b1;
        c0rx_mdata2 = 16'd0;
        c0rx_data2  = make_line(0);
        tick();
        c0rx_valid2 = 1'b0;
        repeat (20) tick();
        total++;
        if (req2_cyc.size() - base != 3)
            $display("FAIL credit_return_count: got %0d reqs want 3", req2_cyc.size() - base);
        else passed++;
        if (req2_cyc.size() - base >= 3) begin
            total++;
            if (req2_cyc[base+2] != r + 4)
                $display("FAIL credit_return_timing: got %0d want 4", req2_cyc[base+2] - r);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        base_addr = '0;
        c0tx_alm_full = 1'b0;
        c0rx_valid = 1'b0;
        c0rx_mdata = '0;
        c0rx_data = '0;
        c0rx_valid2 = 1'b0;
        c0rx_mdata2 = '0;
        c0rx_data2 = '0;
        test_reset();
        test_in_order();
        test_out_of_order();
        test_alm_full();
        test_err_and_busy_start();
        test_reset_mid_fetch();
        test_credits();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
